// File: rtl/wb_mux_pipe_if.sv
// Bus bundle for the writeback mux stage: EX-side capture inputs,
// memory-source read data and the WB-side outputs.
interface wb_mux_pipe_if #(
    parameter int DWIDTH = 32,
    parameter int NSRC   = 3
);
    logic                   stall;
    logic                   flush;
    logic                   ex_valid;
    logic [1:0]             ex_wb_sel;
    logic [2:0]             ex_funct3;
    logic [DWIDTH-1:0]      ex_addr;
    logic [DWIDTH-1:0]      ex_alu;
    logic [DWIDTH-1:0]      ex_pc4;
    logic [4:0]             ex_rd;
    logic [NSRC*DWIDTH-1:0] mem_rdata;
    logic                   wb_valid;
    logic                   wb_we;
    logic [4:0]             wb_rd;
    logic [DWIDTH-1:0]      wb_data;
    logic                   wb_err;

    modport master (
        output stall, flush, ex_valid, ex_wb_sel, ex_funct3, ex_addr,
               ex_alu, ex_pc4, ex_rd, mem_rdata,
        input  wb_valid, wb_we, wb_rd, wb_data, wb_err
    );

    modport slave (
        input  stall, flush, ex_valid, ex_wb_sel, ex_funct3, ex_addr,
               ex_alu, ex_pc4, ex_rd, mem_rdata,
        output wb_valid, wb_we, wb_rd, wb_data, wb_err
    );
endinterface

// File: rtl/wb_mux_pipe.sv
// Writeback stage: registers the EX instruction, then selects ALU, PC+4 or an
// aligned/extended load word from one of NSRC synchronous-read memories.
module wb_mux_pipe #(
    parameter int                DWIDTH = 32,
    parameter int                NSRC   = 3,
    parameter logic [NSRC*4-1:0] SRC_ID = {4'h4, 4'h2, 4'h1}
) (
    input logic          clk,
    input logic          rst,
    wb_mux_pipe_if.slave bus
);
    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic              valid_q, valid_d;
    logic [1:0]        sel_q, sel_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [4:0]        rd_q, rd_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              mapped_q, mapped_d;
    logic [DWIDTH-1:0] alu_q, alu_d;
    logic [DWIDTH-1:0] pc4_q, pc4_d;
    logic [DWIDTH-1:0] hold_q, hold_d;
    logic              held_q, held_d;

    logic              match_hit;
    logic [IW-1:0]     match_idx;
    logic [DWIDTH-1:0] mem_word;
    logic [DWIDTH-1:0] raw_word;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic              misaligned;
    logic              bad_load;
    logic [DWIDTH-1:0] load_data;
    logic [DWIDTH-1:0] data_c;
    logic              err_c;
    logic              unused_addr;

    assign unused_addr = ^bus.ex_addr[DWIDTH-5:2];

    // Scan high to low so the lowest matching index wins.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (SRC_ID[i*4 +: 4] == bus.ex_addr[DWIDTH-1 -: 4]) begin
                match_hit = 1'b1;
                match_idx = IW'(i);
            end
        end
    end

    always_comb begin
        mem_word = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (idx_q == IW'(i)) mem_word = bus.mem_rdata[i*DWIDTH +: DWIDTH];
        end
    end

    always_comb begin
        valid_d  = valid_q;
        sel_d    = sel_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        rd_d     = rd_q;
        idx_d    = idx_q;
        mapped_d = mapped_q;
        alu_d    = alu_q;
        pc4_d    = pc4_q;
        hold_d   = hold_q;
        held_d   = held_q;
        if (!bus.stall) begin
            valid_d  = bus.ex_valid & ~bus.flush;
            sel_d    = bus.ex_wb_sel;
            funct3_d = bus.ex_funct3;
            off_d    = bus.ex_addr[1:0];
            rd_d     = bus.ex_rd;
            idx_d    = match_idx;
            mapped_d = match_hit;
            alu_d    = bus.ex_alu;
            pc4_d    = bus.ex_pc4;
            held_d   = 1'b0;
        end else if (!held_q) begin
            // Memory data is only guaranteed for one cycle; freeze it on the first stalled edge.
            hold_d = mem_word;
            held_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            sel_q    <= 2'b00;
            funct3_q <= 3'b000;
            off_q    <= 2'b00;
            rd_q     <= 5'd0;
            idx_q    <= '0;
            mapped_q <= 1'b0;
            alu_q    <= '0;
            pc4_q    <= '0;
            hold_q   <= '0;
            held_q   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            sel_q    <= sel_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            rd_q     <= rd_d;
            idx_q    <= idx_d;
            mapped_q <= mapped_d;
            alu_q    <= alu_d;
            pc4_q    <= pc4_d;
            hold_q   <= hold_d;
            held_q   <= held_d;
        end
    end

    always_comb begin
        raw_word = held_q ? hold_q : mem_word;
        byte_v   = raw_word[{off_q, 3'b000} +: 8];
        half_v   = off_q[1] ? raw_word[31:16] : raw_word[15:0];
        case (funct3_q)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = off_q[0];
            3'b010:         misaligned = (off_q != 2'b00);
            default:        misaligned = 1'b1;
        endcase
        case (funct3_q)
            3'b000:  load_data = {{(DWIDTH-8){byte_v[7]}}, byte_v};
            3'b100:  load_data = {{(DWIDTH-8){1'b0}}, byte_v};
            3'b001:  load_data = {{(DWIDTH-16){half_v[15]}}, half_v};
            3'b101:  load_data = {{(DWIDTH-16){1'b0}}, half_v};
            3'b010:  load_data = raw_word;
            default: load_data = '0;
        endcase
        bad_load = (sel_q == 2'b10) && (!mapped_q || misaligned);
        case (sel_q)
            2'b01:   data_c = alu_q;
            2'b11:   data_c = pc4_q;
            2'b10:   data_c = bad_load ? '0 : load_data;
            default: data_c = '0;
        endcase
        err_c = valid_q & bad_load;
    end

    assign bus.wb_valid = valid_q;
    assign bus.wb_rd    = rd_q;
    assign bus.wb_data  = data_c;
    assign bus.wb_err   = err_c;
    assign bus.wb_we    = valid_q & (sel_q != 2'b00) & ~err_c & (rd_q != 5'd0);
endmodule

// File: tb/tb_wb_mux_pipe.sv
// Bench for wb_mux_pipe: table of pipelined vectors plus hand-written
// stall-hold and asynchronous-reset sequences, checked through an expected queue.
module tb_wb_mux_pipe;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam int EW = 40;  // {valid, we, err, rd[4:0], data[31:0]}
  localparam int NV = 18;

  typedef struct {
    logic          valid;
    logic          flush;
    logic [1:0]    sel;
    logic [2:0]    f3;
    logic [31:0]   addr;
    logic [31:0]   alu;
    logic [31:0]   pc4;
    logic [4:0]    rd;
    logic [95:0]   mem;
    logic [EW-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];
  vec_t vt[NV];

  wb_mux_pipe_if #(.DWIDTH(DW), .NSRC(NS)) bus ();

  wb_mux_pipe #(.DWIDTH(DW), .NSRC(NS), .SRC_ID(12'h421)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] ex(input logic v, input logic we, input logic err,
                                       input logic [4:0] rd, input logic [31:0] d);
    return {v, we, err, rd, d};
  endfunction

  function automatic vec_t mk(input logic v, input logic fl, input logic [1:0] sel,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] alu, input logic [31:0] pc4,
                              input logic [4:0] rd, input logic [95:0] mem,
                              input logic [EW-1:0] e);
    vec_t r;
    r.valid = v; r.flush = fl; r.sel = sel; r.f3 = f3; r.addr = addr;
    r.alu = alu; r.pc4 = pc4; r.rd = rd; r.mem = mem; r.exp = e;
    return r;
  endfunction

  // driver tasks
  task automatic drive_ex(input vec_t v);
    bus.ex_valid  = v.valid;
    bus.flush     = v.flush;
    bus.ex_wb_sel = v.sel;
    bus.ex_funct3 = v.f3;
    bus.ex_addr   = v.addr;
    bus.ex_alu    = v.alu;
    bus.ex_pc4    = v.pc4;
    bus.ex_rd     = v.rd;
  endtask

  task automatic idle_ex();
    bus.ex_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.ex_wb_sel = 2'b00;
    bus.ex_funct3 = 3'b000;
    bus.ex_addr   = '0;
    bus.ex_alu    = '0;
    bus.ex_pc4    = '0;
    bus.ex_rd     = 5'd0;
  endtask

  // scoreboard
  task automatic check_out(input string nm);
    logic [EW-1:0] act;
    logic [EW-1:0] e;
    act = {bus.wb_valid, bus.wb_we, bus.wb_err, bus.wb_rd, bus.wb_data};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no expected entry queued, got %h", nm, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e)
      begin
        n_bad++;
        $display("FAIL %s: got v=%b we=%b err=%b rd=%0d data=%h, want v=%b we=%b err=%b rd=%0d data=%h",
                 nm, act[39], act[38], act[37], act[36:32], act[31:0],
                 e[39], e[38], e[37], e[36:32], e[31:0]);
      end
    end
  endtask

  initial begin
    vt[0]  = mk(1, 0, 2'b10, 3'b000, 32'h1000_0003, 0, 0, 5'd5,  {32'h0, 32'h0, 32'h80FF_1234}, ex(1, 1, 0, 5'd5, 32'hFFFF_FF80));
    vt[1]  = mk(1, 0, 2'b10, 3'b100, 32'h1000_0001, 0, 0, 5'd6,  {32'h0, 32'h0, 32'h80FF_1234}, ex(1, 1, 0, 5'd6, 32'h0000_0012));
    vt[2]  = mk(1, 0, 2'b10, 3'b001, 32'h2000_0002, 0, 0, 5'd7,  {32'h0, 32'h9ABC_5678, 32'h0}, ex(1, 1, 0, 5'd7, 32'hFFFF_9ABC));
    vt[3]  = mk(1, 0, 2'b10, 3'b101, 32'h4000_0000, 0, 0, 5'd8,  {32'h1234_8001, 32'h0, 32'h0}, ex(1, 1, 0, 5'd8, 32'h0000_8001));
    vt[4]  = mk(1, 0, 2'b10, 3'b010, 32'h4000_0000, 0, 0, 5'd9,  {32'hDEAD_BEEF, 32'h0, 32'h0}, ex(1, 1, 0, 5'd9, 32'hDEAD_BEEF));
    vt[5]  = mk(1, 0, 2'b10, 3'b010, 32'h7000_0000, 0, 0, 5'd10, {3{32'hFFFF_FFFF}},            ex(1, 0, 1, 5'd10, 32'h0));
    vt[6]  = mk(1, 0, 2'b10, 3'b010, 32'h1000_0002, 0, 0, 5'd11, {3{32'hFFFF_FFFF}},            ex(1, 0, 1, 5'd11, 32'h0));
    vt[7]  = mk(1, 0, 2'b10, 3'b001, 32'h2000_0001, 0, 0, 5'd12, {3{32'hFFFF_FFFF}},            ex(1, 0, 1, 5'd12, 32'h0));
    vt[8]  = mk(1, 0, 2'b10, 3'b011, 32'h1000_0000, 0, 0, 5'd13, {3{32'hFFFF_FFFF}},            ex(1, 0, 1, 5'd13, 32'h0));
    vt[9]  = mk(1, 0, 2'b01, 3'b000, 32'h0, 32'd5, 0, 5'd0,      {3{32'hA5A5_A5A5}},            ex(1, 0, 0, 5'd0, 32'd5));
    vt[10] = mk(1, 1, 2'b01, 3'b000, 32'h0, 32'd7, 0, 5'd3,      {3{32'hA5A5_A5A5}},            ex(0, 0, 0, 5'd3, 32'd7));
    vt[11] = mk(1, 0, 2'b11, 3'b000, 32'h0, 32'hBAD, 32'h1000_0008, 5'd1, {3{32'h0}},           ex(1, 1, 0, 5'd1, 32'h1000_0008));
    vt[12] = mk(1, 0, 2'b10, 3'b010, 32'h2000_0004, 0, 0, 5'd2,  {32'h0, 32'hCAFE_F00D, 32'h0}, ex(1, 1, 0, 5'd2, 32'hCAFE_F00D));
    vt[13] = mk(1, 0, 2'b00, 3'b000, 32'h0, 32'h123, 32'h456, 5'd4, {3{32'h5555_5555}},         ex(1, 0, 0, 5'd4, 32'h0));
    vt[14] = mk(0, 0, 2'b01, 3'b000, 32'h0, 32'h44, 0, 5'd5,     {3{32'h0}},                    ex(0, 0, 0, 5'd5, 32'h44));
    vt[15] = mk(1, 0, 2'b10, 3'b000, 32'h2000_0000, 0, 0, 5'd6,  {32'h2222_2222, 32'h0000_00F0, 32'h1111_1111}, ex(1, 1, 0, 5'd6, 32'hFFFF_FFF0));
    vt[16] = mk(1, 0, 2'b10, 3'b100, 32'h4000_0002, 0, 0, 5'd7,  {32'h00AB_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, ex(1, 1, 0, 5'd7, 32'h0000_00AB));
    vt[17] = mk(1, 0, 2'b10, 3'b010, 32'h1000_0000, 0, 0, 5'd0,  {32'h0, 32'h0, 32'h0000_0001}, ex(1, 0, 0, 5'd0, 32'h0000_0001));

    // reset state, with live-looking inputs present
    bus.stall = 1'b0;
    bus.mem_rdata = {3{32'hFFFF_FFFF}};
    drive_ex(vt[11]);
    #2;
    exp_q.push_back(ex(0, 0, 0, 5'd0, 32'h0));
    check_out("reset_initial");
    @(posedge clk); #1;
    exp_q.push_back(ex(0, 0, 0, 5'd0, 32'h0));
    check_out("reset_held_over_edge");
    @(negedge clk);
    rst = 1'b0;

    // pipelined vector table: EX of k+1 overlaps WB of k
    drive_ex(vt[0]);
    for (int k = 0; k < NV; k++) begin
      @(posedge clk); #1;
      bus.mem_rdata = vt[k].mem;
      exp_q.push_back(vt[k].exp);
      if (k + 1 < NV) drive_ex(vt[k+1]);
      else idle_ex();
      @(negedge clk);
      check_out($sformatf("vec%0d", k));
    end

    // LHU held across 3 stalled cycles while the source data goes to 0; flush ignored
    drive_ex(mk(1, 0, 2'b10, 3'b101, 32'h4000_0002, 0, 0, 5'd9, 96'h0, ex(0, 0, 0, 0, 0)));
    @(posedge clk); #1;
    bus.mem_rdata = {32'h9ABC_0000, 32'h0, 32'h0};
    bus.stall = 1'b1;
    drive_ex(mk(1, 0, 2'b01, 3'b000, 32'h0, 32'h77, 0, 5'd10, 96'h0, ex(0, 0, 0, 0, 0)));
    bus.flush = 1'b1;
    exp_q.push_back(ex(1, 1, 0, 5'd9, 32'h0000_9ABC));
    @(negedge clk);
    check_out("stall_cycle1");
    for (int c = 2; c <= 3; c++) begin
      @(posedge clk); #1;
      bus.mem_rdata = '0;
      exp_q.push_back(ex(1, 1, 0, 5'd9, 32'h0000_9ABC));
      @(negedge clk);
      check_out($sformatf("stall_cycle%0d", c));
    end
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(ex(1, 1, 0, 5'd10, 32'h77));
    @(negedge clk);
    check_out("stall_release");

    // reset pulsed between edges in the middle of a stall
    bus.stall = 1'b1;
    bus.mem_rdata = {3{32'hFFFF_FFFF}};
    @(posedge clk); #1;
    exp_q.push_back(ex(1, 1, 0, 5'd10, 32'h77));
    @(negedge clk);
    check_out("stall_before_rst");
    #1 rst = 1'b1;
    #1;
    exp_q.push_back(ex(0, 0, 0, 5'd0, 32'h0));
    check_out("rst_async_mid_stall");
    #1 rst = 1'b0;
    bus.stall = 1'b0;
    drive_ex(mk(1, 0, 2'b01, 3'b000, 32'h0, 32'h99, 0, 5'd4, 96'h0, ex(0, 0, 0, 0, 0)));
    @(posedge clk); #1;
    exp_q.push_back(ex(1, 1, 0, 5'd4, 32'h99));
    idle_ex();
    @(negedge clk);
    check_out("first_capture_after_rst");

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover_expected: %0d entries unconsumed, want 0", exp_q.size());
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_mux_pipe.md
WB_MUX_PIPE -- requirements
Module: wb_mux_pipe

Interface
REQ-001 Parameter DWIDTH, default 32, data/address width.
REQ-002 Parameter NSRC, default 3, number of synchronous-read memory sources (1..8).
REQ-003 Parameter SRC_ID, default {4'h4, 4'h2, 4'h1}, flattened NSRC x 4-bit region IDs; entry i matches ex_addr[DWIDTH-1 -: 4].
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 stall  in  1  hold the WB stage; no capture.
REQ-007 flush  in  1  kill the instruction entering WB.
REQ-008 ex_valid  in  1  EX stage holds a real instruction.
REQ-009 ex_wb_sel  in  2  00 none, 01 ALU, 10 load, 11 PC+4.
REQ-010 ex_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-011 ex_addr  in  DWIDTH  load address, presented to memories in the same cycle.
REQ-012 ex_alu  in  DWIDTH  ALU result.
REQ-013 ex_pc4  in  DWIDTH  PC+4.
REQ-014 ex_rd  in  5  destination register.
REQ-015 mem_rdata  in  NSRC*DWIDTH  flattened source read data, valid one cycle after address.
REQ-016 wb_valid  out  1  WB stage holds a live instruction.
REQ-017 wb_we  out  1  regfile write enable.
REQ-018 wb_rd  out  5  regfile write address.
REQ-019 wb_data  out  DWIDTH  writeback/forwarding data.
REQ-020 wb_err  out  1  WB load was unmapped or misaligned.

Function
REQ-021 When stall=0, WB registers SHALL capture ex_valid&~flush, ex_wb_sel, ex_funct3, ex_addr[1:0], ex_rd, matched source index, ex_alu and ex_pc4 on each rising edge.
REQ-022 When stall=1, all WB registers SHALL hold; flush during stall SHALL be ignored.
REQ-023 Source match: lowest index i whose SRC_ID entry equals ex_addr[DWIDTH-1 -: 4]; no match marks the load unmapped.
REQ-024 wb_data for sel 01/11 SHALL be the registered ex_alu/ex_pc4; for sel 00 it SHALL be 0.
REQ-025 For loads, raw word SHALL be mem_rdata slice of the registered index in the first WB cycle; latency from EX address to wb_data is exactly 1 cycle.
REQ-026 On the first stalled cycle of a load, the raw word SHALL be latched into a hold register; wb_data SHALL derive from the hold register until stall deasserts.
REQ-027 LB/LBU SHALL select byte addr[1:0], LH/LHU halfword addr[1], LW full word; LB/LH sign-extend, LBU/LHU zero-extend to DWIDTH.
REQ-028 Misaligned: LH/LHU with addr[0]=1, LW with addr[1:0]!=0; undefined funct3 values are treated as misaligned.
REQ-029 Unmapped or misaligned load: wb_data=0, wb_err=1, wb_we=0.
REQ-030 wb_we SHALL equal wb_valid & (sel!=00) & ~wb_err & (wb_rd!=0).
REQ-031 wb_err SHALL be 0 for non-load instructions.
REQ-032 Outputs SHALL be combinational only from WB registers, the hold register and mem_rdata; no EX-to-output path.

Reset
REQ-033 While rst=1, all WB registers and the hold register SHALL clear asynchronously: wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, wb_err=0.
REQ-034 Reset asserted mid-stall SHALL discard the held instruction; the first edge after rst deasserts captures EX normally.

Verification
REQ-035 LB from ID 1, addr offset 3, mem_rdata[0]=32'h80FF_1234 -> next cycle wb_data=32'hFFFF_FF80, wb_we=1.
REQ-036 LHU from ID 4, offset 2, word 32'h9ABC_0000, stall held 3 cycles while source data changes to 0 -> wb_data=32'h0000_9ABC all 3 cycles.
REQ-037 LW from region ID 7 (unmapped) or offset 2 -> wb_data=0, wb_err=1, wb_we=0.
REQ-038 ALU op with ex_rd=0, ex_alu=5 -> wb_data=5, wb_valid=1, wb_we=0; with flush=1 -> wb_valid=0, wb_we=0.
REQ-039 JAL with ex_pc4=32'h1000_0008 immediately followed by LW -> consecutive wb_data 32'h1000_0008 then load word, no bubble.
REQ-040 rst pulsed between clock edges during stall -> all outputs 0 immediately, no clock edge required.
